// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I memory-stage load/store access unit
// Single outstanding request, word-wide valid/ready bus with rvalid read return.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_sum_low,
  output logic [2:0]  resp_ld_type,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        fault_now;
  logic [3:0]  strb_now;
  logic [31:0] wdata_now;

  logic        we_q;
  logic        fault_q;
  logic [1:0]  sum_low_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    fault_now = 1'b0;
    strb_now  = 4'b0000;
    wdata_now = req_wdata;
    if (req_we) begin
      fault_now = (req_funct3 > 3'b010);
    end else begin
      fault_now = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                  (req_funct3 == 3'b111);
    end
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])
      fault_now = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      fault_now = 1'b1;
    // Lane replication lets memory pick bytes purely by strobe.
    case (req_funct3[1:0])
      2'b00: begin
        strb_now  = 4'b0001 << req_addr[1:0];
        wdata_now = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb_now  = 4'b0011 << {req_addr[1], 1'b0};
        wdata_now = {2{req_wdata[15:0]}};
      end
      default: begin
        strb_now  = 4'b1111;
        wdata_now = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = fault_now ? DONE : REQ;
      REQ:     if (mem_ready) state_next = we_q ? DONE : RDATA;
      RDATA:   if (mem_rvalid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      sum_low_q <= 2'b00;
      funct3_q  <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'b0000;
      rdata_q   <= 32'h0;
    end else if (accept) begin
      we_q      <= req_we;
      fault_q   <= fault_now;
      sum_low_q <= req_addr[1:0];
      funct3_q  <= req_funct3;
      addr_q    <= {req_addr[31:2], 2'b00};
      wdata_q   <= req_we ? wdata_now : 32'h0;
      wstrb_q   <= (req_we && !fault_now) ? strb_now : 4'b0000;
      rdata_q   <= 32'h0;
    end else if ((state == RDATA) && mem_rvalid) begin
      rdata_q   <= mem_rdata;
    end
  end

  assign req_ready    = (state == IDLE);
  assign mem_valid    = (state == REQ);
  assign mem_we       = (state == REQ) && we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;
  assign resp_valid   = (state == DONE);
  assign resp_fault   = (state == DONE) && fault_q;
  assign resp_rdata   = ((state == DONE) && !we_q && !fault_q) ? rdata_q : 32'h0;
  assign resp_sum_low = sum_low_q;
  assign resp_ld_type = funct3_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_sum_low;
  logic [2:0]  resp_ld_type;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_rdata(resp_rdata),
    .resp_sum_low(resp_sum_low), .resp_ld_type(resp_ld_type),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    tick();
    req_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(posedge clk);
    tick();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_ld_type", {29'b0, resp_ld_type}, 32'd0);
    rst = 1'b0;
    tick();

    // SB to 0x1003, mem_ready tied high
    mem_ready = 1'b1;
    issue(1'b1, 32'h0000_1003, 32'h0000_00A5, 3'b000);
    chk("sb_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("sb_mem_we", {31'b0, mem_we}, 32'd1);
    chk("sb_mem_wstrb", {28'b0, mem_wstrb}, 32'h8);
    chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_mem_addr", mem_addr, 32'h0000_1000);
    chk("sb_req_ready_busy", {31'b0, req_ready}, 32'd0);
    tick();
    chk("sb_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("sb_resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("sb_resp_rdata", resp_rdata, 32'h0);
    chk("sb_mem_valid_after", {31'b0, mem_valid}, 32'd0);
    tick();
    chk("sb_req_ready_back", {31'b0, req_ready}, 32'd1);
    chk("sb_resp_valid_low", {31'b0, resp_valid}, 32'd0);

    // LBU from 0x2002, mem_ready 3 cycles late, rvalid 2 cycles after handshake
    mem_ready = 1'b0;
    issue(1'b0, 32'h0000_2002, 32'h0, 3'b100);
    for (int i = 0; i < 3; i++) begin
      chk("lbu_mem_valid_wait", {31'b0, mem_valid}, 32'd1);
      chk("lbu_mem_addr", mem_addr, 32'h0000_2000);
      tick();
    end
    chk("lbu_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("lbu_mem_we", {31'b0, mem_we}, 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("lbu_mem_valid_drop", {31'b0, mem_valid}, 32'd0);
    chk("lbu_no_resp_yet", {31'b0, resp_valid}, 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("lbu_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("lbu_resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("lbu_resp_rdata", resp_rdata, 32'h1122_3344);
    chk("lbu_resp_sum_low", {30'b0, resp_sum_low}, 32'd2);
    chk("lbu_resp_ld_type", {29'b0, resp_ld_type}, 32'd4);
    tick();
    chk("lbu_req_ready_back", {31'b0, req_ready}, 32'd1);

    // LW from 0x3002 faults with no bus activity
    mem_ready = 1'b1;
    issue(1'b0, 32'h0000_3002, 32'h0, 3'b010);
    chk("lw_mis_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("lw_mis_resp_fault", {31'b0, resp_fault}, 32'd1);
    chk("lw_mis_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("lw_mis_resp_rdata", resp_rdata, 32'h0);
    chk("lw_mis_req_ready_busy", {31'b0, req_ready}, 32'd0);
    tick();
    chk("lw_mis_req_ready_back", {31'b0, req_ready}, 32'd1);
    chk("lw_mis_mem_valid_idle", {31'b0, mem_valid}, 32'd0);

    // SH to 0x4002
    issue(1'b1, 32'h0000_4002, 32'h1234_BEEF, 3'b001);
    chk("sh_mem_wstrb", {28'b0, mem_wstrb}, 32'hC);
    chk("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_mem_addr", mem_addr, 32'h0000_4000);
    tick();
    chk("sh_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("sh_resp_fault", {31'b0, resp_fault}, 32'd0);
    tick();

    // illegal load funct3 011 and illegal store funct3 100
    issue(1'b0, 32'h0000_5000, 32'h0, 3'b011);
    chk("ld011_resp_fault", {31'b0, resp_fault}, 32'd1);
    chk("ld011_mem_valid", {31'b0, mem_valid}, 32'd0);
    tick();
    issue(1'b1, 32'h0000_5000, 32'hFFFF_FFFF, 3'b100);
    chk("st100_resp_fault", {31'b0, resp_fault}, 32'd1);
    chk("st100_mem_valid", {31'b0, mem_valid}, 32'd0);
    tick();

    // reset pulsed while in RDATA, then a late rvalid
    issue(1'b0, 32'h0000_6000, 32'h0, 3'b010);
    chk("rstmid_mem_valid", {31'b0, mem_valid}, 32'd1);
    tick();
    chk("rstmid_in_rdata", {31'b0, mem_valid | req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    chk("rstmid_resp_ld_type", {29'b0, resp_ld_type}, 32'd0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("rstmid_late_rvalid_resp", {31'b0, resp_valid}, 32'd0);
    chk("rstmid_late_rvalid_ready", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 32'h0000_7004, 32'h0, 3'b010);
    chk("post_rst_mem_addr", mem_addr, 32'h0000_7004);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("post_rst_resp_rdata", resp_rdata, 32'hCAFE_F00D);
    chk("post_rst_resp_ld_type", {29'b0, resp_ld_type}, 32'd2);
    tick();

    // rvalid in the handshake cycle is ignored; the next one is returned
    issue(1'b0, 32'h0000_8002, 32'h0, 3'b001);
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    tick();
    mem_rdata = 32'h5566_7788;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("early_rv_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("early_rv_resp_rdata", resp_rdata, 32'h5566_7788);
    chk("early_rv_sum_low", {30'b0, resp_sum_low}, 32'd2);
    chk("early_rv_ld_type", {29'b0, resp_ld_type}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
